core_window_gen: RTL
====================

// Module: core_window_gen
// PURPOSE
//   Sliding-window former for raster-order pixel streams feeding the conv stage.
//   Accepts one pixel per accepted cycle (row-major, top-left first).
//   Per accepted pixel it presents the KxK neighbourhood whose bottom-right
//   corner is that pixel, using K-1 internal line buffers (shift chains).
//   Only fully populated windows are flagged valid ("valid" conv, no padding).
// PARAMETERS
//   Bits      8    pixel width
//   ImgWidth  28   pixels per row (W); require W >= K
//   ImgHeight 28   rows per frame (H); require H >= K
//   K         3    window edge length; require K >= 2
// PORTS
//   clk_i        in   1           clock, all logic on rising edge
//   rst_i        in   1           synchronous, active-high reset
//   clear_i      in   1           soft frame restart (sync), same effect as rst_i on counters/outputs
//   valid_i      in   1           data_i holds a pixel this cycle; pixel accepted when valid_i & !clear_i
//   data_i       in   Bits        pixel value
//   window_o     out  K*K*Bits    window; element (r,c) at [(r*K+c)*Bits +: Bits], r=0 top row, c=0 left col
//   valid_o      out  1           window_o is a complete window (1-cycle pulse per window)
//   frame_done_o out  1           pulses with the window of the last pixel of the frame
// BEHAVIOUR
//   - Reset (rst_i=1 or clear_i=1 at clk edge): col=0,row=0, valid_o=0, frame_done_o=0,
//     window_o=0. Line-buffer storage is not cleared; stale data is masked by valid gating.
//   - clear_i has priority over valid_i: a pixel presented with clear_i is dropped.
//   - Accepted pixel at (row,col): all line buffers and window regs advance exactly one
//     position; no state changes on cycles without an accepted pixel (bubbles are transparent).
//   - Latency 1: window_o/valid_o registered on the edge that accepts the pixel;
//     visible the following cycle. valid_o=1 iff row>=K-1 and col>=K-1 for that pixel.
//   - window_o(r,c) = pixel at (row-(K-1)+r, col-(K-1)+c) of the current frame.
//   - valid_o deasserts on every cycle without an accepted pixel; window_o holds its value.
//   - Counters: col increments per accepted pixel, wraps W-1 -> 0 with row+1;
//     at (H-1,W-1) both wrap to 0 and frame_done_o=1 with that pixel's window.
//   - Next frame starts on the next accepted pixel; no window spans two frames
//     (row gating guarantees prior-frame rows never appear in a valid window).
//   - Windows per frame: (H-K+1)*(W-K+1). Windows never straddle a row boundary
//     (col gating).
//   - Reset mid-frame: partially received frame discarded; next accepted pixel is (0,0).
//   - Line buffers: K-1 chains, each holding one row's tail; implement with
//     per-row window regs plus W-K deep enable-gated shift chains, sync reset only on control.
// TESTING (W=5,H=4,K=3,Bits=8; pixel p = row*5+col unless stated)
//   1 Stream p=0..19 back-to-back -> valid_o after p=12,13,14,17,18,19 only (6 pulses);
//     after p=12 window_o = {0,1,2,5,6,7,10,11,12} in (r,c) order; frame_done_o only after p=19.
//   2 Same stream with valid_i toggling 1/0 each cycle -> identical window sequence;
//     valid_o never high on the cycle after a bubble.
//   3 Two frames back-to-back, frame 2 pixels = p+100 -> frame 2 first window after its
//     12th index = {100,101,102,105,106,107,110,111,112}; no frame-1 values in any valid window.
//   4 rst_i asserted after p=8, then restart p=0..19 -> outputs exactly as scenario 1;
//     valid_o=0, window_o=0, frame_done_o=0 in the cycle after reset.
//   5 clear_i with valid_i=1 on p=12 -> pixel dropped, no valid_o; next pixel counted as (0,0).
//   6 Parameter sweep K=2 and K=W=H=3 -> windows per frame = (H-K+1)*(W-K+1); last pulse
//     coincides with frame_done_o.

Source files
------------

// File: rtl/core_window_gen.sv
// Sliding KxK window former for raster-order pixel streams.
// Every accepted pixel advances line buffers and window by one position; only fully populated windows are flagged valid.
module core_window_gen #(
    parameter int Bits      = 8,
    parameter int ImgWidth  = 28,
    parameter int ImgHeight = 28,
    parameter int K         = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [Bits-1:0]       data_i,
    output logic [K*K*Bits-1:0]   window_o,
    output logic                  valid_o,
    output logic                  frame_done_o
);
    localparam int Depth = ImgWidth - K;
    localparam int ColW  = $clog2(ImgWidth);
    localparam int RowW  = $clog2(ImgHeight);

    logic                  accept;
    logic [ColW-1:0]       col_reg;
    logic [RowW-1:0]       row_reg;
    logic                  valid_reg;
    logic                  frame_done_reg;
    logic                  blank_reg;
    logic                  last_col;
    logic                  last_row;
    logic                  full_window;

    // One row of the window per entry, column 0 in the least significant slot.
    logic [K*Bits-1:0]     win_row_reg [K];
    logic [K-1:0][Bits-1:0] row_in;

    assign accept      = valid_i & ~clear_i;
    assign last_col    = (col_reg == ColW'(ImgWidth - 1));
    assign last_row    = (row_reg == RowW'(ImgHeight - 1));
    assign full_window = (row_reg >= RowW'(K - 1)) && (col_reg >= ColW'(K - 1));

    assign row_in[K-1] = data_i;

    // Each upper window row is fed by the pixel exactly one image row behind it.
    genvar gi;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_line
            if (Depth == 0) begin : g_direct
                assign row_in[gi] = win_row_reg[gi+1][Bits-1:0];
            end else begin : g_chain
                logic [Bits-1:0] lb_reg [Depth];
                always_ff @(posedge clk_i) begin
                    if (accept) begin
                        lb_reg[0] <= win_row_reg[gi+1][Bits-1:0];
                        for (int i = 1; i < Depth; i++) begin
                            lb_reg[i] <= lb_reg[i-1];
                        end
                    end
                end
                assign row_in[gi] = lb_reg[Depth-1];
            end
        end

        for (gi = 0; gi < K; gi++) begin : g_win
            always_ff @(posedge clk_i) begin
                if (accept) begin
                    win_row_reg[gi] <= {row_in[gi], win_row_reg[gi][K*Bits-1:Bits]};
                end
            end
            // Storage is never cleared, so the output is forced to zero until the first pixel after a restart.
            assign window_o[gi*K*Bits +: K*Bits] = blank_reg ? '0 : win_row_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            col_reg        <= '0;
            row_reg        <= '0;
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            blank_reg      <= 1'b1;
        end else begin
            valid_reg      <= accept && full_window;
            frame_done_reg <= accept && last_row && last_col;
            if (accept) begin
                blank_reg <= 1'b0;
                if (last_col) begin
                    col_reg <= '0;
                    if (last_row) begin
                        row_reg <= '0;
                    end else begin
                        row_reg <= row_reg + RowW'(1);
                    end
                end else begin
                    col_reg <= col_reg + ColW'(1);
                end
            end
        end
    end

    assign valid_o      = valid_reg;
    assign frame_done_o = frame_done_reg;
endmodule
